// File: rtl/cmplx_mult_seq_if.sv
// Handshake and multiplier bus bundle for the complex-multiply sequencer.
// The slave modport is the sequencer side. The master modport is the side
// that supplies operands, returns products and accepts results.
interface cmplx_mult_seq_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  a_re;
  logic signed [7:0]  a_im;
  logic signed [7:0]  b_re;
  logic signed [7:0]  b_im;
  logic               mult_start;
  logic signed [7:0]  mult_in_0;
  logic signed [7:0]  mult_in_1;
  logic signed [15:0] mult_out;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] out_re;
  logic signed [16:0] out_im;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, mult_out, out_ready,
    output in_ready, mult_start, mult_in_0, mult_in_1, out_valid, out_re, out_im
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, mult_out, out_ready,
    input  in_ready, mult_start, mult_in_0, mult_in_1, out_valid, out_re, out_im
  );
endinterface

// File: rtl/cmplx_mult_seq.sv
// Complex-multiply sequencer. It computes (a_re + j*a_im) * (b_re + j*b_im)
// using four real products from one shared sequential multiplier. The
// partial products are accumulated in 17-bit registers, so no result can wrap.
module cmplx_mult_seq #(
  parameter int MULT_LATENCY = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  cmplx_mult_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [7:0]  ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic signed [16:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic               in_ready_q, in_ready_d;
  logic               mult_start_q, mult_start_d;
  logic signed [7:0]  mult_in_0_q, mult_in_0_d, mult_in_1_q, mult_in_1_d;
  logic               out_valid_q, out_valid_d;
  logic signed [16:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [16:0] p;
  logic [1:0]         k_nxt;

  // Product order: k=0 re*re, k=1 im*im, k=2 re*im, k=3 im*re.
  function automatic logic signed [7:0] sel_a(input logic [1:0] k,
                                              input logic signed [7:0] re,
                                              input logic signed [7:0] im);
    return k[0] ? im : re;
  endfunction

  function automatic logic signed [7:0] sel_b(input logic [1:0] k,
                                              input logic signed [7:0] re,
                                              input logic signed [7:0] im);
    return (k[0] ^ k[1]) ? im : re;
  endfunction

  // Next-state, operand sequencing and accumulation.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    ar_d         = ar_q;
    ai_d         = ai_q;
    br_d         = br_q;
    bi_d         = bi_q;
    acc_re_d     = acc_re_q;
    acc_im_d     = acc_im_q;
    mult_start_d = 1'b0;
    mult_in_0_d  = mult_in_0_q;
    mult_in_1_d  = mult_in_1_q;
    out_valid_d  = out_valid_q;
    out_re_d     = out_re_q;
    out_im_d     = out_im_q;
    p            = {{9{bus.mult_out[15]}}, bus.mult_out};
    k_nxt        = 2'(k_q + 2'd1);
    case (state_q)
      IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          ar_d         = bus.a_re;
          ai_d         = bus.a_im;
          br_d         = bus.b_re;
          bi_d         = bus.b_im;
          k_d          = 2'd0;
          acc_re_d     = '0;
          acc_im_d     = '0;
          // Operands for k=0 come straight from the inputs so ISSUE starts at once.
          mult_in_0_d  = bus.a_re;
          mult_in_1_d  = bus.b_re;
          mult_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 8'(MULT_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          case (k_q)
            2'd0:    acc_re_d = acc_re_q + p;
            2'd1:    acc_re_d = acc_re_q - p;
            default: acc_im_d = acc_im_q + p;
          endcase
          if (k_q != 2'd3) begin
            k_d          = k_nxt;
            mult_in_0_d  = sel_a(k_nxt, ar_q, ai_q);
            mult_in_1_d  = sel_b(k_nxt, br_q, bi_q);
            mult_start_d = 1'b1;
            state_d      = ISSUE;
          end else begin
            out_re_d    = acc_re_d;
            out_im_d    = acc_im_d;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      ar_q         <= '0;
      ai_q         <= '0;
      br_q         <= '0;
      bi_q         <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      in_ready_q   <= 1'b0;
      mult_start_q <= 1'b0;
      mult_in_0_q  <= '0;
      mult_in_1_q  <= '0;
      out_valid_q  <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      ar_q         <= ar_d;
      ai_q         <= ai_d;
      br_q         <= br_d;
      bi_q         <= bi_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      in_ready_q   <= in_ready_d;
      mult_start_q <= mult_start_d;
      mult_in_0_q  <= mult_in_0_d;
      mult_in_1_q  <= mult_in_1_d;
      out_valid_q  <= out_valid_d;
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mult_start = mult_start_q;
  assign bus.mult_in_0  = mult_in_0_q;
  assign bus.mult_in_1  = mult_in_1_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Bench for cmplx_mult_seq. It uses a behavioural fixed-latency multiplier
// and a result scoreboard.
module tb_cmplx_mult_seq;
  localparam int L = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmplx_mult_seq_if bus();
  cmplx_mult_seq #(.MULT_LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;
  int last_lat = 0;
  int exp_re_q[$];
  int exp_im_q[$];
  int acc_cyc_q[$];
  int acc_hist[$];
  int start_q[$];
  int op0_q[$];
  int op1_q[$];
  logic [L-1:0] vpipe;
  logic signed [15:0] prod;
  logic out_valid_prev = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle counter and scoreboard push on each accepted operand set.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_re_q.push_back(int'(bus.a_re) * int'(bus.b_re) - int'(bus.a_im) * int'(bus.b_im));
      exp_im_q.push_back(int'(bus.a_re) * int'(bus.b_im) + int'(bus.a_im) * int'(bus.b_re));
      acc_cyc_q.push_back(cyc);
      acc_hist.push_back(cyc);
    end
  end

  // Multiplier model: the product is valid L edges after the start pulse is sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe <= '0;
    else        vpipe <= {vpipe[L-2:0], bus.mult_start};
  end

  // Product driven from the operands still on the bus; junk at all other times.
  always @(negedge clk) begin
    prod = bus.mult_in_0 * bus.mult_in_1;
    bus.mult_out = vpipe[L-1] ? prod : 16'($urandom);
  end

  // Record every start pulse with its operands.
  always @(negedge clk) begin
    if (bus.mult_start) begin
      start_q.push_back(cyc);
      op0_q.push_back(int'(bus.mult_in_0));
      op1_q.push_back(int'(bus.mult_in_1));
    end
  end

  // Compare each new result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !out_valid_prev) begin
      if (exp_re_q.size() == 0) begin
        chk("unexpected_out", exp_re_q.size(), 1);
      end else begin
        chk("out_re", bus.out_re, exp_re_q.pop_front());
        chk("out_im", bus.out_im, exp_im_q.pop_front());
        last_lat = cyc - acc_cyc_q.pop_front();
      end
      n_done++;
    end
    out_valid_prev = bus.out_valid;
  end

  task automatic send(input int ar, input int ai, input int br, input int bi);
    int n = 0;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", bus.in_ready, 1);
    bus.a_re = 8'(ar);
    bus.a_im = 8'(ai);
    bus.b_re = 8'(br);
    bus.b_im = 8'(bi);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (n_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n_done < target) chk("done_timeout", n_done, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_mult_start"}, bus.mult_start, 0);
    chk({tag, "_mult_in_0"}, bus.mult_in_0, 0);
    chk({tag, "_mult_in_1"}, bus.mult_in_1, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_re"}, bus.out_re, 0);
    chk({tag, "_out_im"}, bus.out_im, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op0_exp[4];
    int op1_exp[4];
    int v_ar[3];
    int v_ai[3];
    int v_br[3];
    int v_bi[3];
    int idx;
    logic signed [16:0] hold_re, hold_im;

    bus.in_valid = 1'b0;
    bus.a_re = '0;
    bus.a_im = '0;
    bus.b_re = '0;
    bus.b_im = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", bus.in_ready, 1);

    // Test 1: latency and start pulse spacing
    start_q.delete();
    send(6, 0, -5, 0);
    wait_done(1);
    chk("t1_latency", last_lat, 4 * (L + 1));
    chk("t1_start_count", start_q.size(), 4);
    for (int i = 1; i < 4 && i < start_q.size(); i++)
      chk("t1_start_spacing", start_q[i] - start_q[i-1], L + 1);

    // Test 2: operand order
    @(negedge clk);
    op0_q.delete();
    op1_q.delete();
    send(3, 4, 2, -1);
    wait_done(2);
    op0_exp = '{3, 4, 3, 4};
    op1_exp = '{2, -1, -1, 2};
    chk("t2_op_count", op0_q.size(), 4);
    for (int i = 0; i < 4 && i < op0_q.size(); i++) begin
      chk("t2_op0", op0_q[i], op0_exp[i]);
      chk("t2_op1", op1_q[i], op1_exp[i]);
    end

    // Test 3: extreme operands
    send(-128, -128, -128, 127);
    wait_done(3);
    send(-128, -128, -128, -128);
    wait_done(4);

    // Test 4: output back-pressure
    @(negedge clk);
    bus.out_ready = 1'b0;
    start_q.delete();
    send(5, -7, -3, 9);
    wait_done(5);
    hold_re = bus.out_re;
    hold_im = bus.out_im;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_out_valid", bus.out_valid, 1);
      chk("t4_out_re_stable", bus.out_re, hold_re);
      chk("t4_out_im_stable", bus.out_im, hold_im);
      chk("t4_in_ready", bus.in_ready, 0);
      bus.in_valid = ~bus.in_valid;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_out_valid_drop", bus.out_valid, 0);
    chk("t4_in_ready_back", bus.in_ready, 1);
    chk("t4_no_extra_starts", start_q.size(), 4);
    chk("t4_sb_empty", exp_re_q.size(), 0);

    // Test 5: reset during the k=2 wait
    start_q.delete();
    send(7, -2, 3, 5);
    for (int n = 0; n < 500 && start_q.size() < 3; n++) @(negedge clk);
    chk("t5_reached_k2", start_q.size(), 3);
    repeat (3) @(negedge clk);
    chk("t5_pre_rst_mult_in_0", bus.mult_in_0, 7);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t5");
    exp_re_q.delete();
    exp_im_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_partial", n_done, 5);
    send(1, 1, 1, 1);
    wait_done(6);

    // Test 6: back-to-back with in_valid held high
    @(negedge clk);
    v_ar = '{10, -100, 127};
    v_ai = '{-20, 50, -128};
    v_br = '{30, -60, 127};
    v_bi = '{40, -70, -128};
    acc_hist.delete();
    idx = 0;
    for (int n = 0; n < 1000 && idx <= 3; n++) begin
      if (bus.in_ready) begin
        if (idx == 3) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a_re = 8'(v_ar[idx]);
          bus.a_im = 8'(v_ai[idx]);
          bus.b_re = 8'(v_br[idx]);
          bus.b_im = 8'(v_bi[idx]);
          bus.in_valid = 1'b1;
        end
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_done(9);
    chk("t6_accepts", acc_hist.size(), 3);
    for (int i = 1; i < acc_hist.size(); i++)
      chk("t6_accept_spacing", acc_hist[i] - acc_hist[i-1], 4 * (L + 1) + 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
